ah_packet_converter_n2w: RTL and testbench
==========================================

# ah_packet_converter_n2w

Parametrised narrow-to-wide packet gearbox; successor to the fixed 20→32 converter. Accepts IN_W-bit beats on a credit-flow-controlled write side and packs them LSB-first into OUT_W-bit words on a credit-flow-controlled read side. Supports any IN_W ≤ OUT_W, including non-integer ratios. Packet boundaries are carried through: a zero-padded partial word closes each packet. Sits between a narrow link layer and the wide datapath.

## Interface
- IN_W, 20, input beat width; 1 ≤ IN_W ≤ OUT_W
- OUT_W, 32, output word width
- IN_CREDITS, 4, input FIFO depth = credits held by upstream after reset; ≥ 2
- OUT_CREDITS, 4, credits held by this block toward downstream after reset; ≥ 1
- clk  in  1  clock; one clock domain
- rstn  in  1  asynchronous active-low reset
- wdata  in  IN_W  input beat
- wlast  in  1  beat is last of its packet
- wvalid  in  1  beat present; upstream only asserts while holding a credit
- wcredit  out  1  one-cycle pulse; returns one input credit
- rdata  out  OUT_W  packed output word
- rlast  out  1  word closes a packet
- rvalid  out  1  word transferred this cycle (no stall; credit already held)
- rcredit  in  1  one-cycle pulse; downstream returns one credit
- err  out  1  sticky protocol-error flag

## Operation
- Input FIFO, IN_CREDITS entries of {wlast, wdata}. Push on wvalid. Pop when the gearbox absorbs. Each pop pulses wcredit in the same cycle.
- wvalid while FIFO full: drop the beat, set err. err clears only on reset.
- Gearbox holds buf (BUF_W = OUT_W+IN_W bits), cnt (valid bits, 0..BUF_W) and flush_pend.
- Emit condition: ocred > 0 and (cnt ≥ OUT_W or (flush_pend and cnt > 0)).
  - On emit: rvalid=1, rdata = buf[OUT_W-1:0] with bits ≥ cnt forced to 0.
  - rlast = flush_pend and cnt ≤ OUT_W.
  - Then buf shifts right by OUT_W and cnt -= min(cnt, OUT_W).
  - If rlast, clear flush_pend.
- Absorb condition: FIFO non-empty, !flush_pend, and (cnt − emitted bits + IN_W) ≤ BUF_W.
  - On absorb: the beat is written at bit position (post-emit cnt); cnt += IN_W.
  - If the beat has wlast, set flush_pend.
- Emit and absorb may occur in the same cycle; emit is applied first.
- A new packet is never absorbed until the previous packet's rlast word has emitted. No word mixes bits from two packets.
- Output credit counter ocred, reset OUT_CREDITS.
  - Update: ocred += rcredit − rvalid.
  - rcredit with ocred == OUT_CREDITS and no same-cycle emit: ignore it and set err.
- IN_W == OUT_W degenerates to a pass-through: one word per beat; rlast equals the beat's wlast.

## Timing
- Reset values: wcredit 0, rvalid 0, rlast 0, rdata 0, err 0, cnt 0, flush_pend 0, FIFO empty, ocred OUT_CREDITS.
- Beat pushed at edge N is absorbable in cycle N+1.
- A word completed by that absorb has rvalid in cycle N+2, given credit. Minimum latency is 2 cycles.
- wcredit is asserted in the absorb cycle, earliest cycle N+1.
- rvalid/rdata/rlast are decoded from registered state only; no combinational path from any input.
- rcredit in cycle M makes the credit usable in cycle M+1.
- Sustained throughput with ample credits: one beat per cycle in; IN_W/OUT_W words per cycle out.
- Reset mid-packet discards FIFO contents, buf and partial words. No rvalid or wcredit is generated for them.

## Structure
- Shared package ah_pkt_conv_pkg:
  - width-check function (1 ≤ IN_W ≤ OUT_W)
  - $clog2-based counter-width localparams for cnt and ocred
- Sub-module ah_credit_fifo (WIDTH, DEPTH): flop-based FIFO with push/pop, full/empty and overflow indication. The gearbox and credit logic stay in the top.
- Elaboration-time error when IN_W > OUT_W or IN_CREDITS < 2.

## Test plan
- 20→32, beats A,B,C,D, no wlast, credits ample:
  - {B[11:0],A} at cycle 3
  - {D[3:0],C,B[19:12]} after D
  - cnt=16 remains
- 20→32, A,B,C with wlast on C:
  - {B[11:0],A} with rlast=0
  - then {4'h0,C,B[19:12]} with rlast=1
  - next packet's first beat is absorbed only after that rlast word.
- OUT_CREDITS=1, no rcredit:
  - exactly one rvalid, then output stalls
  - FIFO fills; wcredit stops after IN_CREDITS+ beats are absorbed
  - one rcredit pulse → exactly one more word, earliest the next cycle.
- 8→32, 5 beats, wlast on beat 5:
  - word0 = beats1-4, rlast=0
  - word1 = {24'h0, beat5}, rlast=1.
- Protocol violations:
  - wvalid with FIFO full → beat dropped, err=1
  - extra rcredit at full credit → err=1, ocred stays OUT_CREDITS.
- rstn low mid-packet (cnt=28):
  - all outputs return to reset values immediately
  - after release, a fresh 2-beat 20→32 packet produces one word with no residue from before reset.

Source files
------------

// File: rtl/ah_pkt_conv_pkg.sv
// Shared helpers for the narrow-to-wide packet gearbox: parameter checks and
// counter widths derived from the data widths and credit counts.
package ah_pkt_conv_pkg;

    function automatic bit width_ok(input int in_w, input int out_w);
        return (in_w >= 1) && (in_w <= out_w);
    endfunction

    // cnt spans 0..OUT_W+IN_W inclusive.
    function automatic int cnt_width(input int in_w, input int out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

    // ocred spans 0..credits inclusive.
    function automatic int cred_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    localparam int DEF_IN_W   = 20;
    localparam int DEF_OUT_W  = 32;
    localparam int DEF_CNT_W  = cnt_width(DEF_IN_W, DEF_OUT_W);
    localparam int DEF_CRED_W = cred_width(4);

endpackage

// File: rtl/ah_credit_fifo.sv
// Flop-based FIFO backing the input credits; pushes while full are dropped
// and flagged on overflow for that cycle.
module ah_credit_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign overflow = push && full;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ah_packet_converter_n2w.sv
// Narrow-to-wide packet gearbox: IN_W-bit beats packed LSB-first into OUT_W-bit
// words; each packet closes with a zero-padded word carrying rlast.
//
// Flow control: the write side is credit based -- upstream starts with
// IN_CREDITS credits, spends one per wvalid beat and regains one per wcredit
// pulse. The read side mirrors it: a word goes out (rvalid) only while this
// block holds an output credit, and downstream returns credits via rcredit.
// Neither side can stall a transfer once it is presented.
module ah_packet_converter_n2w
    import ah_pkt_conv_pkg::*;
#(
    parameter int IN_W        = 20,
    parameter int OUT_W       = 32,
    parameter int IN_CREDITS  = 4,
    parameter int OUT_CREDITS = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IN_W-1:0]  wdata,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wcredit,
    output logic [OUT_W-1:0] rdata,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rcredit,
    output logic             err
);
    localparam int BUF_W  = OUT_W + IN_W;
    localparam int CNT_W  = cnt_width(IN_W, OUT_W);
    localparam int CW1    = CNT_W + 1;
    localparam int CRED_W = cred_width(OUT_CREDITS);

    if (!width_ok(IN_W, OUT_W)) begin : g_bad_width
        $error("ah_packet_converter_n2w: need 1 <= IN_W <= OUT_W");
    end
    if (IN_CREDITS < 2) begin : g_bad_in_credits
        $error("ah_packet_converter_n2w: IN_CREDITS must be >= 2");
    end
    if (OUT_CREDITS < 1) begin : g_bad_out_credits
        $error("ah_packet_converter_n2w: OUT_CREDITS must be >= 1");
    end

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt, cnt_d, emitted, post_cnt;
    logic              flush_pend, flush_d;
    logic [CRED_W-1:0] ocred, ocred_d;
    logic              err_d, emit, absorb, cred_ovf;
    logic [CW1-1:0]    room_need;
    logic [IN_W:0]     fifo_dout;
    logic              fifo_full, fifo_empty, fifo_ovf;

    ah_credit_fifo #(
        .WIDTH (IN_W + 1),
        .DEPTH (IN_CREDITS)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (wvalid),
        .din      ({wlast, wdata}),
        .pop      (absorb),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // Everything driving the outputs comes from registers, so no input
    // reaches rvalid/rdata/rlast/wcredit combinationally.
    always_comb begin
        emit      = (ocred != '0) &&
                    ((cnt >= CNT_W'(OUT_W)) || (flush_pend && (cnt != '0)));
        emitted   = emit ? ((cnt >= CNT_W'(OUT_W)) ? CNT_W'(OUT_W) : cnt) : '0;
        post_cnt  = cnt - emitted;
        room_need = {1'b0, post_cnt} + CW1'(IN_W);
        absorb    = !fifo_empty && !flush_pend && (room_need <= CW1'(BUF_W));

        rvalid  = emit;
        rlast   = emit && flush_pend && (cnt <= CNT_W'(OUT_W));
        wcredit = absorb;
        rdata   = '0;
        for (int i = 0; i < OUT_W; i++)
            rdata[i] = emit && buf_q[i] && (CNT_W'(i) < cnt);

        buf_d = emit ? (buf_q >> OUT_W) : buf_q;
        if (absorb)
            buf_d = buf_d | (BUF_W'(fifo_dout[IN_W-1:0]) << post_cnt);
        cnt_d = post_cnt + (absorb ? CNT_W'(IN_W) : '0);

        // rlast implies flush_pend, which blocks absorb, so the two never collide.
        flush_d = flush_pend;
        if (rlast)
            flush_d = 1'b0;
        if (absorb && fifo_dout[IN_W])
            flush_d = 1'b1;

        cred_ovf = rcredit && (ocred == CRED_W'(OUT_CREDITS)) && !emit;
        ocred_d  = ocred + CRED_W'(rcredit && !cred_ovf) - CRED_W'(emit);
        err_d    = err || fifo_ovf || cred_ovf;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_q      <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            ocred      <= CRED_W'(OUT_CREDITS);
            err        <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            cnt        <= cnt_d;
            flush_pend <= flush_d;
            ocred      <= ocred_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_ah_packet_converter_n2w.sv
// Directed bench for ah_packet_converter_n2w: three instances (20->32, 20->32 with
// one output credit, 8->32), a shared expected-word scoreboard per instance.
module tb_ah_packet_converter_n2w;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // u0: 20->32, 4/4 credits
    logic [19:0] wdata0 = '0;
    logic        wlast0 = 1'b0, wvalid0 = 1'b0, rcredit0 = 1'b0;
    logic        wcredit0, rlast0, rvalid0, err0;
    logic [31:0] rdata0;
    // u1: 20->32, 4 input credits, 1 output credit
    logic [19:0] wdata1 = '0;
    logic        wlast1 = 1'b0, wvalid1 = 1'b0, rcredit1 = 1'b0;
    logic        wcredit1, rlast1, rvalid1, err1;
    logic [31:0] rdata1;
    // u2: 8->32, 4/4 credits
    logic [7:0]  wdata2 = '0;
    logic        wlast2 = 1'b0, wvalid2 = 1'b0, rcredit2 = 1'b0;
    logic        wcredit2, rlast2, rvalid2, err2;
    logic [31:0] rdata2;

    ah_packet_converter_n2w #(.IN_W(20), .OUT_W(32), .IN_CREDITS(4), .OUT_CREDITS(4)) u0 (
        .clk(clk), .rstn(rstn), .wdata(wdata0), .wlast(wlast0), .wvalid(wvalid0),
        .wcredit(wcredit0), .rdata(rdata0), .rlast(rlast0), .rvalid(rvalid0),
        .rcredit(rcredit0), .err(err0));
    ah_packet_converter_n2w #(.IN_W(20), .OUT_W(32), .IN_CREDITS(4), .OUT_CREDITS(1)) u1 (
        .clk(clk), .rstn(rstn), .wdata(wdata1), .wlast(wlast1), .wvalid(wvalid1),
        .wcredit(wcredit1), .rdata(rdata1), .rlast(rlast1), .rvalid(rvalid1),
        .rcredit(rcredit1), .err(err1));
    ah_packet_converter_n2w #(.IN_W(8), .OUT_W(32), .IN_CREDITS(4), .OUT_CREDITS(4)) u2 (
        .clk(clk), .rstn(rstn), .wdata(wdata2), .wlast(wlast2), .wvalid(wvalid2),
        .wcredit(wcredit2), .rdata(rdata2), .rlast(rlast2), .rvalid(rvalid2),
        .rcredit(rcredit2), .err(err2));

    // Scoreboard entries are {rlast, rdata}.
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];
    int rv_cnt1 = 0;
    int wc_cnt1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected word for every rvalid, independent of stimulus.
    always @(negedge clk) begin
        if (!rstn) begin
            rv_cnt1 = 0;
            wc_cnt1 = 0;
        end else begin
            if (rvalid0) begin
                chk("u0_word", {rlast0, rdata0}, (exp_q0.size() != 0) ? exp_q0.pop_front() : 33'bx);
                if (rlast0) chk("u0_no_absorb_on_rlast", wcredit0, 0);
            end
            if (rvalid1) begin
                chk("u1_word", {rlast1, rdata1}, (exp_q1.size() != 0) ? exp_q1.pop_front() : 33'bx);
                rv_cnt1++;
            end
            if (wcredit1) wc_cnt1++;
            if (rvalid2) begin
                chk("u2_word", {rlast2, rdata2}, (exp_q2.size() != 0) ? exp_q2.pop_front() : 33'bx);
                if (rlast2) chk("u2_no_absorb_on_rlast", wcredit2, 0);
            end
        end
    end

    // Downstream models for u0/u2: return each credit the cycle after its word.
    logic man_cred0 = 1'b0;
    initial begin
        logic p0, p2;
        forever begin
            @(negedge clk);
            p0 = rvalid0;
            p2 = rvalid2;
            @(posedge clk);
            #1;
            rcredit0 = p0 || man_cred0;
            man_cred0 = 1'b0;
            rcredit2 = p2;
        end
    end

    task automatic beat0(input logic [19:0] d, input logic l);
        wdata0 = d; wlast0 = l; wvalid0 = 1'b1;
        @(posedge clk); #1;
        wvalid0 = 1'b0; wlast0 = 1'b0;
    endtask

    task automatic beat1(input logic [19:0] d, input logic l);
        wdata1 = d; wlast1 = l; wvalid1 = 1'b1;
        @(posedge clk); #1;
        wvalid1 = 1'b0; wlast1 = 1'b0;
    endtask

    task automatic beat2(input logic [7:0] d, input logic l);
        wdata2 = d; wlast2 = l; wvalid2 = 1'b1;
        @(posedge clk); #1;
        wvalid2 = 1'b0; wlast2 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && (exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0; i++)
            @(negedge clk);
        chk(name, exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
    task automatic pulse_reset(input string name);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk({name, "_rvalid"}, rvalid0, 0);
        chk({name, "_wcredit"}, wcredit0, 0);
        chk({name, "_rlast"}, rlast0, 0);
        chk({name, "_rdata"}, rdata0, 0);
        chk({name, "_err"}, err0, 0);
        chk({name, "_cnt"}, u0.cnt, 0);
        chk({name, "_ocred"}, u0.ocred, 4);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    localparam logic [19:0] A = 20'h12345, B = 20'h6789A, C = 20'hBCDEF, D = 20'h13579;
    localparam logic [19:0] E = 20'hFEDCB, F = 20'h31415, G = 20'h0ACE1, H = 20'h24680;

    initial begin
        // Reset state
        #3;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_wcredit2", wcredit2, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_ocred0", u0.ocred, 4);

        // 20->32 continuous beats, no wlast
        exp_q0.push_back({1'b0, 32'h89A12345});
        exp_q0.push_back({1'b0, 32'h9BCDEF67});
        chk("wcredit_idle", wcredit0, 0);
        beat0(A, 1'b0);
        chk("wcredit_n1", wcredit0, 1);
        beat0(B, 1'b0);
        chk("lat_not_yet", rvalid0, 0);
        beat0(C, 1'b0);
        chk("lat_word0", rvalid0, 1);
        beat0(D, 1'b0);
        wait_drain("t1_drain");
        chk("t1_residue_cnt", u0.cnt, 16);
        pulse_reset("rst_a");

        // Packet A,B,C(last) followed at once by packet G(last)
        exp_q0.push_back({1'b0, 32'h89A12345});
        exp_q0.push_back({1'b1, 32'h0BCDEF67});
        exp_q0.push_back({1'b1, 32'h0000ACE1});
        beat0(A, 1'b0);
        beat0(B, 1'b0);
        beat0(C, 1'b1);
        beat0(G, 1'b1);
        wait_drain("t2_drain");
        chk("t2_cnt_empty", u0.cnt, 0);

        // One output credit, no returns: one word, then FIFO fills
        exp_q1.push_back({1'b0, 32'h89A12345});
        exp_q1.push_back({1'b0, 32'h9BCDEF67});
        beat1(A, 1'b0); beat1(B, 1'b0); beat1(C, 1'b0); beat1(D, 1'b0);
        beat1(E, 1'b0); beat1(F, 1'b0); beat1(G, 1'b0); beat1(H, 1'b0);
        chk("u1_err_before_ovf", err1, 0);
        beat1(20'h55555, 1'b0);
        chk("u1_err_on_ovf", err1, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("u1_one_word", rv_cnt1, 1);
        chk("u1_absorbed", wc_cnt1, 4);
        rcredit1 = 1'b1;
        chk("u1_no_word_same_cycle", rvalid1, 0);
        @(posedge clk); #1;
        rcredit1 = 1'b0;
        chk("u1_word_next_cycle", rvalid1, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("u1_two_words", rv_cnt1, 2);
        chk("u1_absorbed_after", wc_cnt1, 5);
        chk("u1_err_sticky", err1, 1);
        exp_q1.delete();

        // 8->32, five beats, wlast on the fifth
        exp_q2.push_back({1'b0, 32'h44332211});
        exp_q2.push_back({1'b1, 32'h00000055});
        beat2(8'h11, 1'b0); beat2(8'h22, 1'b0); beat2(8'h33, 1'b0);
        beat2(8'h44, 1'b0); beat2(8'h55, 1'b1);
        wait_drain("u2_drain");
        chk("u2_err", err2, 0);

        // Extra credit at full count
        chk("u0_err_clean", err0, 0);
        man_cred0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("u0_err_extra_cred", err0, 1);
        chk("u0_ocred_capped", u0.ocred, 4);

        // Reset mid-packet with 28 bits held
        exp_q0.push_back({1'b0, 32'h89A12345});
        beat0(A, 1'b0);
        beat0(B, 1'b0);
        beat0(C, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_cnt28", u0.cnt, 28);
        chk("mid_err_sticky", err0, 1);
        chk("mid_drained", exp_q0.size(), 0);
        pulse_reset("rst_mid");
        exp_q0.push_back({1'b0, 32'h415FEDCB});
        exp_q0.push_back({1'b1, 32'h00000031});
        beat0(E, 1'b0);
        beat0(F, 1'b1);
        wait_drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
